// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receiver.
package i2c_pkg;

  localparam int ADDR_W = 7;

  // sda_oe levels: the slave ACKs by pulling SDA low
  localparam logic ACK_LEVEL  = 1'b1;
  localparam logic NACK_LEVEL = 1'b0;
  localparam logic RW_WRITE   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;

  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [ADDR_W-1:0] dev_addr);
    return (addr_byte[7:1] == dev_addr) && (addr_byte[0] == RW_WRITE);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one I2C line plus rise/fall strobes on the
// synchronized level. Flops reset to 1, the idle level of an I2C bus.
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b1;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= 1'b1;
    else        prev_reg <= sync_reg[STAGES-1];
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C slave: matches a 7-bit address, ACKs it and every data byte,
// and presents each received byte with a one-cycle rx_valid pulse.
module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DEV_ADDR    = 7'h48,
  parameter int                SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_start,
  output logic       rx_stop,
  output logic       busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (scl_in),
    .level (scl_level),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sda_in),
    .level (sda_level),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;

  state_t      state_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic        byte_done_reg;

  // In the ACK states sda_oe doubles as the phase flag: the first SCL fall
  // starts driving, the second one releases and moves on to DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      byte_done_reg <= 1'b0;
      sda_oe        <= NACK_LEVEL;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_start      <= 1'b0;
      rx_stop       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_start <= 1'b0;
      rx_stop  <= 1'b0;
      if (start_det) begin
        state_reg     <= ST_ADDR;
        bit_cnt_reg   <= 3'd0;
        shift_reg     <= 8'h00;
        byte_done_reg <= 1'b0;
        sda_oe        <= NACK_LEVEL;
        rx_start      <= 1'b1;
      end else if (stop_det) begin
        state_reg     <= ST_IDLE;
        byte_done_reg <= 1'b0;
        sda_oe        <= NACK_LEVEL;
        rx_stop       <= 1'b1;
      end else begin
        case (state_reg)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_level};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                state_reg <= addr_match({shift_reg[6:0], sda_level}, DEV_ADDR)
                             ? ST_ADDR_ACK : ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (scl_fall) begin
              if (sda_oe == ACK_LEVEL) begin
                sda_oe    <= NACK_LEVEL;
                state_reg <= ST_DATA;
              end else begin
                sda_oe    <= ACK_LEVEL;
              end
            end
          end
          ST_DATA: begin
            if (byte_done_reg) begin
              rx_data       <= shift_reg;
              rx_valid      <= 1'b1;
              byte_done_reg <= 1'b0;
              state_reg     <= ST_DATA_ACK;
            end else if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_level};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
            end
          end
          ST_IDLE, ST_IGNORE: begin
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state_reg != ST_IDLE);

endmodule
